// File: rtl/button_conditioner.sv
// button_conditioner
// N-channel push-button front end. Each raw pin is optionally inverted, then
// synchronised and debounced, and produces a clean level, press/release pulses
// and a one-shot long-press pulse. Aggregate any/all levels and any-edge pulses
// are derived from the next-state levels so that they change in the same cycle
// as the per-channel levels.
module button_conditioner #(
    parameter int NUM_BTN           = 4,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 100000000,
    parameter bit ACTIVE_LOW        = 1'b0
) (
    input  logic               I_CLK,
    input  logic               I_RST_N,
    input  logic [NUM_BTN-1:0] I_BTN,
    output logic [NUM_BTN-1:0] O_LEVEL,
    output logic [NUM_BTN-1:0] O_RISE,
    output logic [NUM_BTN-1:0] O_FALL,
    output logic [NUM_BTN-1:0] O_LONG,
    output logic               O_ANY_LEVEL,
    output logic               O_ALL_LEVEL,
    output logic               O_ANY_RISE,
    output logic               O_ANY_FALL
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // One counter serves both the debounce windows and the hold timer.
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ? DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam bit LONG_EN = (LONG_PRESS_CYCLES > 0);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    // With the detector disabled the hold compare value is never used.
    localparam logic [CNT_W-1:0] LONG_LAST = LONG_EN ? CNT_W'(LONG_PRESS_CYCLES - 1) : {CNT_W{1'b0}};

    logic [NUM_BTN-1:0] sync_r [SYNC_STAGES];
    logic [NUM_BTN-1:0] btn_s;

    state_t             state_r     [NUM_BTN];
    state_t             state_nxt_s [NUM_BTN];
    logic [CNT_W-1:0]   cnt_r       [NUM_BTN];
    logic [CNT_W-1:0]   cnt_nxt_s   [NUM_BTN];

    logic [NUM_BTN-1:0] fired_r, fired_nxt_s;
    logic [NUM_BTN-1:0] level_r, level_nxt_s;
    logic [NUM_BTN-1:0] rise_r, rise_nxt_s;
    logic [NUM_BTN-1:0] fall_r, fall_nxt_s;
    logic [NUM_BTN-1:0] long_r, long_nxt_s;
    logic               any_r, all_r, any_rise_r, any_fall_r;
    logic               any_nxt_s;

    // Polarity normalisation followed by the metastability synchroniser chain.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= {NUM_BTN{1'b0}};
            end
        end else begin
            sync_r[0] <= I_BTN ^ {NUM_BTN{ACTIVE_LOW}};
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    assign btn_s = sync_r[SYNC_STAGES-1];

    // Per-channel debounce / hold FSM: next state, counter and output pulses.
    always_comb begin
        level_nxt_s = level_r;
        rise_nxt_s  = {NUM_BTN{1'b0}};
        fall_nxt_s  = {NUM_BTN{1'b0}};
        long_nxt_s  = {NUM_BTN{1'b0}};
        fired_nxt_s = fired_r;
        for (int i = 0; i < NUM_BTN; i++) begin
            state_nxt_s[i] = state_r[i];
            cnt_nxt_s[i]   = cnt_r[i];
            case (state_r[i])
                ST_IDLE: begin
                    cnt_nxt_s[i] = CNT_ZERO;
                    if (btn_s[i]) begin
                        state_nxt_s[i] = ST_PRESS_WAIT;
                    end else begin
                        fired_nxt_s[i] = 1'b0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!btn_s[i]) begin
                        // Too short to count as a press: drop it silently.
                        state_nxt_s[i] = ST_IDLE;
                        cnt_nxt_s[i]   = CNT_ZERO;
                        fired_nxt_s[i] = 1'b0;
                    end else if (cnt_r[i] == DEB_LAST) begin
                        state_nxt_s[i] = ST_PRESSED;
                        cnt_nxt_s[i]   = CNT_ZERO;
                        level_nxt_s[i] = 1'b1;
                        rise_nxt_s[i]  = 1'b1;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (!btn_s[i]) begin
                        state_nxt_s[i] = ST_RELEASE_WAIT;
                        cnt_nxt_s[i]   = CNT_ZERO;
                    end else if (LONG_EN && (cnt_r[i] == LONG_LAST)) begin
                        // Saturate at the threshold; only the first arrival fires.
                        if (!fired_r[i]) begin
                            long_nxt_s[i]  = 1'b1;
                            fired_nxt_s[i] = 1'b1;
                        end else begin
                            cnt_nxt_s[i] = cnt_r[i];
                        end
                    end else if (LONG_EN) begin
                        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i];
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (btn_s[i]) begin
                        // Dropout rejected; the press continues but keeps its fired flag.
                        state_nxt_s[i] = ST_PRESSED;
                        cnt_nxt_s[i]   = CNT_ZERO;
                    end else if (cnt_r[i] == DEB_LAST) begin
                        state_nxt_s[i] = ST_IDLE;
                        cnt_nxt_s[i]   = CNT_ZERO;
                        level_nxt_s[i] = 1'b0;
                        fall_nxt_s[i]  = 1'b1;
                        fired_nxt_s[i] = 1'b0;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s[i] = ST_IDLE;
                    cnt_nxt_s[i]   = CNT_ZERO;
                    level_nxt_s[i] = 1'b0;
                    fired_nxt_s[i] = 1'b0;
                end
            endcase
        end
        any_nxt_s = |level_nxt_s;
    end

    // State, counter and registered output update for all channels and aggregates.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_r[i] <= ST_IDLE;
                cnt_r[i]   <= CNT_ZERO;
            end
            fired_r    <= {NUM_BTN{1'b0}};
            level_r    <= {NUM_BTN{1'b0}};
            rise_r     <= {NUM_BTN{1'b0}};
            fall_r     <= {NUM_BTN{1'b0}};
            long_r     <= {NUM_BTN{1'b0}};
            any_r      <= 1'b0;
            all_r      <= 1'b0;
            any_rise_r <= 1'b0;
            any_fall_r <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_r[i] <= state_nxt_s[i];
                cnt_r[i]   <= cnt_nxt_s[i];
            end
            fired_r    <= fired_nxt_s;
            level_r    <= level_nxt_s;
            rise_r     <= rise_nxt_s;
            fall_r     <= fall_nxt_s;
            long_r     <= long_nxt_s;
            any_r      <= any_nxt_s;
            all_r      <= &level_nxt_s;
            any_rise_r <= any_nxt_s & ~any_r;
            any_fall_r <= ~any_nxt_s & any_r;
        end
    end

    assign O_LEVEL     = level_r;
    assign O_RISE      = rise_r;
    assign O_FALL      = fall_r;
    assign O_LONG      = long_r;
    assign O_ANY_LEVEL = any_r;
    assign O_ALL_LEVEL = all_r;
    assign O_ANY_RISE  = any_rise_r;
    assign O_ANY_FALL  = any_fall_r;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
// Drives two instances (active-high and active-low pins fed inverted stimulus)
// and checks every cycle against expected output vectors queued per scenario.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] btn_n;

    logic [3:0] lvl0, rise0, fall0, long0;
    logic       anyl0, alll0, anyr0, anyf0;
    logic [3:0] lvl1, rise1, fall1, long1;
    logic       anyl1, alll1, anyr1, anyf1;

    logic [19:0] obs0, obs1;
    logic [19:0] sb_q [$];
    logic        prev_any;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign btn_n = ~btn;
    assign obs0  = {lvl0, rise0, fall0, long0, anyl0, alll0, anyr0, anyf0};
    assign obs1  = {lvl1, rise1, fall1, long1, anyl1, alll1, anyr1, anyf1};

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .LONG_PRESS_CYCLES(10), .ACTIVE_LOW(1'b0)
    ) dut (
        .I_CLK(clk), .I_RST_N(rst_n), .I_BTN(btn),
        .O_LEVEL(lvl0), .O_RISE(rise0), .O_FALL(fall0), .O_LONG(long0),
        .O_ANY_LEVEL(anyl0), .O_ALL_LEVEL(alll0),
        .O_ANY_RISE(anyr0), .O_ANY_FALL(anyf0)
    );

    button_conditioner #(
        .NUM_BTN(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
        .LONG_PRESS_CYCLES(10), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .I_CLK(clk), .I_RST_N(rst_n), .I_BTN(btn_n),
        .O_LEVEL(lvl1), .O_RISE(rise1), .O_FALL(fall1), .O_LONG(long1),
        .O_ANY_LEVEL(anyl1), .O_ALL_LEVEL(alll1),
        .O_ANY_RISE(anyr1), .O_ANY_FALL(anyf1)
    );

    // Expected output vector from per-channel expectations; aggregates follow their definitions.
    function automatic logic [19:0] mk_exp(input logic [3:0] lv, input logic [3:0] rs,
                                           input logic [3:0] fl, input logic [3:0] lg,
                                           input logic pa);
        logic a;
        a = |lv;
        return {lv, rs, fl, lg, a, &lv, a & ~pa, ~a & pa};
    endfunction

    task automatic test_reset();
        logic [19:0] ev;
        logic [3:0]  lv, rs, fl;
        prev_any = 1'b0;
        btn   = 4'hF;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (obs0 !== 20'h0) begin n_bad++; $display("FAIL reset_async dut=%h exp=%h", obs0, 20'h0); end
        n_cmp++; if (obs1 !== 20'h0) begin n_bad++; $display("FAIL reset_async_al dut=%h exp=%h", obs1, 20'h0); end
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_cmp++; if (obs0 !== 20'h0) begin n_bad++; $display("FAIL reset_edge0 dut=%h exp=%h", obs0, 20'h0); end
        n_cmp++; if (obs1 !== 20'h0) begin n_bad++; $display("FAIL reset_edge0_al dut=%h exp=%h", obs1, 20'h0); end
        for (int e = 1; e <= 20; e++) begin
            btn = (e <= 8) ? 4'hF : 4'h0;
            lv  = (e >= 7 && e <= 14) ? 4'hF : 4'h0;
            rs  = (e == 7) ? 4'hF : 4'h0;
            fl  = (e == 15) ? 4'hF : 4'h0;
            sb_q.push_back(mk_exp(lv, rs, fl, 4'h0, prev_any));
            prev_any = |lv;
            @(posedge clk); #1;
            ev = sb_q.pop_front();
            n_cmp++; if (obs0 !== ev) begin n_bad++; $display("FAIL reset_exit e=%0d dut=%h exp=%h", e, obs0, ev); end
            n_cmp++; if (obs1 !== ev) begin n_bad++; $display("FAIL reset_exit_al e=%0d dut=%h exp=%h", e, obs1, ev); end
        end
    endtask

    task automatic test_long_press();
        logic [19:0] ev;
        logic [3:0]  lv, rs, fl, lg;
        prev_any = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            btn = {3'b000, (e <= 30)};
            lv  = {3'b000, (e >= 7 && e <= 36)};
            rs  = {3'b000, (e == 7)};
            fl  = {3'b000, (e == 37)};
            lg  = {3'b000, (e == 17)};
            sb_q.push_back(mk_exp(lv, rs, fl, lg, prev_any));
            prev_any = |lv;
            @(posedge clk); #1;
            ev = sb_q.pop_front();
            n_cmp++; if (obs0 !== ev) begin n_bad++; $display("FAIL long_press e=%0d dut=%h exp=%h", e, obs0, ev); end
            n_cmp++; if (obs1 !== ev) begin n_bad++; $display("FAIL long_press_al e=%0d dut=%h exp=%h", e, obs1, ev); end
        end
    endtask

    task automatic test_glitch_dropout();
        logic [19:0] ev;
        logic [3:0]  lv, rs, fl, lg;
        logic        b;
        prev_any = 1'b0;
        for (int e = 1; e <= 86; e++) begin
            b   = (e <= 3) || (e >= 10 && e <= 14) || (e >= 30 && e <= 49) || (e >= 53 && e <= 75);
            btn = {2'b00, b, 1'b0};
            lv  = {2'b00, ((e >= 16 && e <= 20) || (e >= 36 && e <= 81)), 1'b0};
            rs  = {2'b00, (e == 16 || e == 36), 1'b0};
            fl  = {2'b00, (e == 21 || e == 82), 1'b0};
            lg  = {2'b00, (e == 46), 1'b0};
            sb_q.push_back(mk_exp(lv, rs, fl, lg, prev_any));
            prev_any = |lv;
            @(posedge clk); #1;
            ev = sb_q.pop_front();
            n_cmp++; if (obs0 !== ev) begin n_bad++; $display("FAIL glitch_dropout e=%0d dut=%h exp=%h", e, obs0, ev); end
            n_cmp++; if (obs1 !== ev) begin n_bad++; $display("FAIL glitch_dropout_al e=%0d dut=%h exp=%h", e, obs1, ev); end
        end
    endtask

    task automatic test_simultaneous();
        logic [19:0] ev;
        logic [3:0]  lv, rs, fl, lg;
        prev_any = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            btn = {(e <= 21), (e <= 19), 2'b00};
            lv  = {(e >= 7 && e <= 27), (e >= 7 && e <= 25), 2'b00};
            rs  = (e == 7) ? 4'b1100 : 4'b0000;
            fl  = {(e == 28), (e == 26), 2'b00};
            lg  = (e == 17) ? 4'b1100 : 4'b0000;
            sb_q.push_back(mk_exp(lv, rs, fl, lg, prev_any));
            prev_any = |lv;
            @(posedge clk); #1;
            ev = sb_q.pop_front();
            n_cmp++; if (obs0 !== ev) begin n_bad++; $display("FAIL simultaneous e=%0d dut=%h exp=%h", e, obs0, ev); end
            n_cmp++; if (obs1 !== ev) begin n_bad++; $display("FAIL simultaneous_al e=%0d dut=%h exp=%h", e, obs1, ev); end
        end
    endtask

    task automatic test_reset_release_wait();
        logic [19:0] ev;
        logic [3:0]  lv, rs;
        prev_any = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            btn = {3'b000, (e <= 11)};
            lv  = {3'b000, (e >= 7)};
            rs  = {3'b000, (e == 7)};
            sb_q.push_back(mk_exp(lv, rs, 4'h0, 4'h0, prev_any));
            prev_any = |lv;
            @(posedge clk); #1;
            ev = sb_q.pop_front();
            n_cmp++; if (obs0 !== ev) begin n_bad++; $display("FAIL rst_rw_pre e=%0d dut=%h exp=%h", e, obs0, ev); end
            n_cmp++; if (obs1 !== ev) begin n_bad++; $display("FAIL rst_rw_pre_al e=%0d dut=%h exp=%h", e, obs1, ev); end
        end
        // Channel 0 is now in its release debounce window.
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (obs0 !== 20'h0) begin n_bad++; $display("FAIL rst_rw_async dut=%h exp=%h", obs0, 20'h0); end
        n_cmp++; if (obs1 !== 20'h0) begin n_bad++; $display("FAIL rst_rw_async_al dut=%h exp=%h", obs1, 20'h0); end
        prev_any = 1'b0;
        for (int e = 16; e <= 30; e++) begin
            btn = 4'h0;
            sb_q.push_back(mk_exp(4'h0, 4'h0, 4'h0, 4'h0, prev_any));
            @(posedge clk); #1;
            if (e == 16) rst_n = 1'b1;
            ev = sb_q.pop_front();
            n_cmp++; if (obs0 !== ev) begin n_bad++; $display("FAIL rst_rw_post e=%0d dut=%h exp=%h", e, obs0, ev); end
            n_cmp++; if (obs1 !== ev) begin n_bad++; $display("FAIL rst_rw_post_al e=%0d dut=%h exp=%h", e, obs1, ev); end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_long_press();
        test_glitch_dropout();
        test_simultaneous();
        test_reset_release_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Run-time bound.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised N-channel push-button front end: per channel synchroniser, debouncer, edge pulses and long-press detector.
- Also produces aggregate any/all levels and any-button edge pulses.
- Sits between raw GPIO_SW_* pins and the LCD/display FSMs and LED logic.
- Replaces ad-hoc two-flop synchronisers and edge detection in top-level wrappers.

Parameters:
- NUM_BTN, 4, number of button channels (1..16).
- SYNC_STAGES, 2, synchroniser flop depth per channel (2..4).
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised input must be stable before a level change is accepted (>=1).
- LONG_PRESS_CYCLES, 100000000, cycles in the debounced-pressed state before O_LONG pulses. 0 disables the long-press detector.
- ACTIVE_LOW, 0, 1 = raw pins read 0 when pressed; inverted before the synchroniser.

Ports:
- I_CLK  in  1  system clock (USER_CLK).
- I_RST_N  in  1  reset, asynchronous assert, active-low.
- I_BTN  in  NUM_BTN  raw asynchronous button pins.
- O_LEVEL  out  NUM_BTN  debounced pressed level per channel.
- O_RISE  out  NUM_BTN  1-cycle pulse per channel on debounced press.
- O_FALL  out  NUM_BTN  1-cycle pulse per channel on debounced release.
- O_LONG  out  NUM_BTN  1-cycle pulse per channel when a hold reaches LONG_PRESS_CYCLES.
- O_ANY_LEVEL  out  1  OR of O_LEVEL.
- O_ALL_LEVEL  out  1  AND of O_LEVEL.
- O_ANY_RISE  out  1  1-cycle pulse when O_ANY_LEVEL goes 0->1.
- O_ANY_FALL  out  1  1-cycle pulse when O_ANY_LEVEL goes 1->0.

Behaviour:
- Reset (I_RST_N=0, asynchronous):
  - All synchroniser flops cleared to "not pressed".
  - All channel FSMs go to IDLE; all counters cleared.
  - All outputs 0.
  - Reset asserted mid-debounce or mid-hold abandons the operation; no pulses are emitted on or after reset exit.
- Input conditioning: raw bit XOR ACTIVE_LOW, then SYNC_STAGES flops. Call the result s[i].
- Per-channel FSM, counter cnt of width clog2(max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)+1):
  - IDLE (level 0): s=1 -> PRESS_WAIT, cnt<=0.
  - PRESS_WAIT: s=0 -> IDLE (glitch rejected, no output). Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> PRESSED, O_LEVEL<=1, O_RISE<=1, cnt<=0. Otherwise cnt++.
  - PRESSED (level 1): s=0 -> RELEASE_WAIT, cnt<=0. Otherwise hold count runs (below).
  - RELEASE_WAIT (level stays 1): s=1 -> PRESSED; hold count resumes from 0 and O_LONG does not re-fire for this press. Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> IDLE, O_LEVEL<=0, O_FALL<=1. Otherwise cnt++.
- Latency: raw edge settling before clock edge k gives O_LEVEL change and the RISE/FALL pulse after edge k+SYNC_STAGES+DEBOUNCE_CYCLES.
- Long press (LONG_PRESS_CYCLES>0):
  - In PRESSED, cnt increments each cycle.
  - When cnt==LONG_PRESS_CYCLES-1, O_LONG pulses once and a per-channel fired flag is set.
  - cnt then saturates. The fired flag clears on entering IDLE.
  - At most one O_LONG per debounced press.
  - LONG_PRESS_CYCLES=0: O_LONG tied 0.
- Pulses: O_RISE, O_FALL and O_LONG are registered and high exactly one cycle. O_RISE and O_FALL are mutually exclusive per channel.
- Aggregates:
  - O_ANY_LEVEL and O_ALL_LEVEL are registered and updated in the same cycle as O_LEVEL.
  - O_ANY_RISE = next_any & ~any, and O_ANY_FALL = ~next_any & any, both registered in the same cycle as the aggregate change.
  - Simultaneous rises on several channels produce a single O_ANY_RISE.
  - A rise on one channel coincident with a fall on the last other pressed channel keeps O_ANY_LEVEL=1 and produces no aggregate pulse.
- Channels are fully independent; no priority between them.

Test Plan:
Bench parameters: NUM_BTN=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, ACTIVE_LOW=0.
- Reset with I_BTN=4'b1111 held, then I_RST_N released at edge 0 -> all outputs 0 through edge 0. O_LEVEL=4'b1111 with one O_RISE=4'b1111 and a single O_ANY_RISE after edge 7.
- I_BTN[0] raised before edge 1 and held -> O_LEVEL[0]=1, O_RISE[0] and O_ANY_RISE high only in the cycle after edge 7. O_LONG[0] pulses once after edge 17 and never again while held.
- I_BTN[1] glitch high for 3 cycles -> no change on any output. A 5-cycle high pulse -> O_RISE[1] once. A 3-cycle low dropout while pressed -> no O_FALL[1] and no second O_LONG[1].
- Channels 2 and 3 pressed on the same cycle, then released 2 cycles apart -> one O_ANY_RISE. O_ALL_LEVEL stays 0. O_FALL[2] and O_FALL[3] are 2 cycles apart, with O_ANY_FALL only on the second.
- I_RST_N pulsed low for 1 cycle while channel 0 is in RELEASE_WAIT -> O_LEVEL[0] drops asynchronously. No O_FALL[0] and no O_ANY_FALL are emitted.
- ACTIVE_LOW=1 rerun of the second scenario with an inverted stimulus -> identical output timing.
